// File: rtl/decoder3to8_pulse.sv
// Buffered 3-to-8 decoder: accepts binary codes over valid/ready, queues them in a
// small FIFO and replays each as a registered one-hot strobe with a fixed idle gap.
module decoder3to8_pulse #(
  parameter int unsigned PULSE_LEN  = 2,
  parameter int unsigned GAP_LEN    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [2:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              idle_next;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  // No pass-through: a pop this cycle never frees room for a push this cycle.
  assign push  = in_valid && !full;
  // A pop coincides with loading a new strobe, from IDLE or at the end of a gap.
  assign pop   = !empty && ((state == IDLE) || ((state == GAP) && (tmr == '0)));
  assign idle_next = empty && ((state == IDLE) || ((state == GAP) && (tmr == '0)));

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Code storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and the flags derived from next-cycle occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_next;
      in_ready <= (count_next != CNT_W'(FIFO_DEPTH));
      busy     <= (count_next != '0) || !idle_next;
    end
  end

  // Strobe sequencer; out_data moves only between zero and one-hot values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_data  <= 8'b1 << mem[rd_ptr];
      out_valid <= 1'b1;
      tmr       <= TMR_W'(PULSE_LEN - 1);
      state     <= PULSE;
    end else begin
      unique case (state)
        IDLE: begin
          out_data  <= '0;
          out_valid <= 1'b0;
        end
        PULSE: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
          end else begin
            out_data  <= '0;
            out_valid <= 1'b0;
            tmr       <= TMR_W'(GAP_LEN - 1);
            state     <= GAP;
          end
        end
        GAP: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          out_data  <= '0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder3to8_pulse.sv
// Self-checking bench for decoder3to8_pulse: default-parameter instance with a
// strobe scoreboard, plus a PULSE_LEN=1/GAP_LEN=3 instance for a timing trace.
module tb_decoder3to8_pulse;

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid_a = 1'b0;
  logic [2:0] in_data_a = '0;
  logic       in_ready_a;
  logic [7:0] out_data_a;
  logic       out_valid_a;
  logic       busy_a;

  logic       in_valid_b = 1'b0;
  logic [2:0] in_data_b = '0;
  logic       in_ready_b;
  logic [7:0] out_data_b;
  logic       out_valid_b;
  logic       busy_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] q_a[$];
  bit         mon_en = 1'b0;
  logic [7:0] prev;
  int         run_len;
  int         zero_len;
  bit         b2b;

  vec_t tbl_all[8];
  vec_t tbl_bp[7];
  logic [7:0] trace_b[6];

  always #5 clk = ~clk;

  decoder3to8_pulse #(.PULSE_LEN(2), .GAP_LEN(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_data(out_data_a), .out_valid(out_valid_a), .busy(busy_a)
  );

  decoder3to8_pulse #(.PULSE_LEN(1), .GAP_LEN(3), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_data(out_data_b), .out_valid(out_valid_b), .busy(busy_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Holds in_valid until the code is taken; called and returns at posedge+1.
  task automatic push_a(input logic [2:0] code, input logic [7:0] exp);
    logic rdy;
    bit   done = 1'b0;
    in_valid_a = 1'b1;
    in_data_a  = code;
    for (int i = 0; i < 100 && !done; i++) begin
      rdy = in_ready_a;
      @(posedge clk);
      #1;
      if (rdy) begin
        q_a.push_back(exp);
        done = 1'b1;
      end
    end
    if (!done) fail("push_timeout");
  endtask

  task automatic wait_idle_a();
    bit idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      if (!busy_a) idle = 1'b1;
    end
    if (!idle) fail("idle_timeout");
    check("queue_drained", q_a.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Strobe monitor: order, one-hot, pulse width and back-to-back gap width.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        prev = '0; run_len = 0; zero_len = 0; b2b = 1'b0;
      end else begin
        check("valid_matches_data", int'(out_valid_a), int'(out_data_a != 8'h00));
        if (out_data_a != 8'h00) begin
          check("one_hot", $countones(out_data_a), 1);
          if (prev == 8'h00) begin
            if (b2b) check("gap_len", zero_len, 1);
            if (q_a.size() == 0) fail("unexpected_strobe");
            else check("code_order", int'(out_data_a), int'(q_a.pop_front()));
            run_len = 1;
          end else begin
            check("strobe_hold", int'(out_data_a), int'(prev));
            run_len++;
          end
        end else begin
          if (prev != 8'h00) begin
            check("pulse_len", run_len, 2);
            b2b = (q_a.size() != 0);
            zero_len = 0;
          end
          zero_len++;
        end
        prev = out_data_a;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl_all[0] = '{3'd0, 8'h01}; tbl_all[1] = '{3'd1, 8'h02};
    tbl_all[2] = '{3'd2, 8'h04}; tbl_all[3] = '{3'd3, 8'h08};
    tbl_all[4] = '{3'd4, 8'h10}; tbl_all[5] = '{3'd5, 8'h20};
    tbl_all[6] = '{3'd6, 8'h40}; tbl_all[7] = '{3'd7, 8'h80};
    tbl_bp[0] = '{3'd3, 8'h08}; tbl_bp[1] = '{3'd1, 8'h02};
    tbl_bp[2] = '{3'd6, 8'h40}; tbl_bp[3] = '{3'd0, 8'h01};
    tbl_bp[4] = '{3'd7, 8'h80}; tbl_bp[5] = '{3'd2, 8'h04};
    tbl_bp[6] = '{3'd4, 8'h10};
    trace_b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_data", int'(out_data_a), 0);
    check("rst_out_valid", int'(out_valid_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_in_ready", int'(in_ready_a), 1);
    check("rst_in_ready_b", int'(in_ready_b), 1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single code: one-cycle latency, two-cycle strobe, busy clears after the gap
    push_a(3'd5, 8'h20);
    in_valid_a = 1'b0;
    @(negedge clk);
    check("latency_pre", int'(out_data_a), 0);
    check("busy_after_push", int'(busy_a), 1);
    @(negedge clk);
    check("single_strobe_0", int'(out_data_a), 'h20);
    @(negedge clk);
    check("single_strobe_1", int'(out_data_a), 'h20);
    @(negedge clk);
    check("single_gap", int'(out_data_a), 0);
    check("busy_in_gap", int'(busy_a), 1);
    @(negedge clk);
    check("busy_after_gap", int'(busy_a), 0);
    @(posedge clk);
    #1;

    // Every code back to back
    for (int i = 0; i < 8; i++) push_a(tbl_all[i].code, tbl_all[i].exp);
    in_valid_a = 1'b0;
    wait_idle_a();

    // Back-pressure: six accepts fill the FIFO, the seventh waits for a pop
    for (int i = 0; i < 6; i++) push_a(tbl_bp[i].code, tbl_bp[i].exp);
    check("ready_low_full", int'(in_ready_a), 0);
    in_valid_a = 1'b1;
    in_data_a  = tbl_bp[6].code;
    @(posedge clk);
    #1;
    check("ready_held_full", int'(in_ready_a), 0);
    @(posedge clk);
    #1;
    check("pop_edge_strobe", int'(out_data_a), int'(tbl_bp[2].exp));
    check("ready_after_pop", int'(in_ready_a), 1);
    @(posedge clk);
    #1;
    q_a.push_back(tbl_bp[6].exp);
    in_valid_a = 1'b0;
    check("ready_after_refill", int'(in_ready_a), 0);
    wait_idle_a();

    // Reset mid-pulse flushes the queued code
    push_a(3'd2, 8'h04);
    push_a(3'd6, 8'h40);
    in_valid_a = 1'b0;
    @(negedge clk);
    check("pre_reset_strobe", int'(out_data_a), 'h04);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("reset_out_zero", int'(out_data_a), 0);
    check("reset_valid_zero", int'(out_valid_a), 0);
    check("reset_busy_zero", int'(busy_a), 0);
    check("reset_ready_high", int'(in_ready_a), 1);
    q_a.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_strobe", int'(out_data_a), 0);
    end
    check("post_reset_busy", int'(busy_a), 0);
    @(posedge clk);
    #1;

    // PULSE_LEN=1, GAP_LEN=3 trace on the second instance
    in_valid_b = 1'b1;
    in_data_b  = 3'd1;
    @(posedge clk);
    #1;
    in_data_b = 3'd7;
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("sweep_data", int'(out_data_b), int'(trace_b[j]));
      check("sweep_valid", int'(out_valid_b), int'(trace_b[j] != 8'h00));
    end
    repeat (3) @(negedge clk);
    check("sweep_busy_done", int'(busy_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder3to8_pulse.md
# decoder3to8_pulse

Sequential 3-to-8 decoder that is the receiving end of the team's 8-to-3 encoder path. It accepts 3-bit binary codes over a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a registered one-hot strobe on an 8-bit bus, held for a fixed pulse width, with a fixed idle gap between consecutive strobes. It sits downstream of the encoder and drives one-hot select/strobe lines.

## Interface
- PULSE_LEN, 2: cycles each one-hot strobe is held; legal range 1..15.
- GAP_LEN, 1: cycles of all-zero output between consecutive strobes; legal range 1..15.
- FIFO_DEPTH, 4: code buffer entries; power of two, at least 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; state is cleared while low.
- in_valid  input  1  in_data carries a code.
- in_ready  output  1  FIFO can accept a code; equals !full.
- in_data  input  3  binary code 0..7.
- out_data  output  8  registered one-hot strobe (1 << code) or 8'b0.
- out_valid  output  1  high exactly when out_data is non-zero.
- busy  output  1  FIFO non-empty or FSM not in IDLE.

## Operation
- Reset values: out_data=8'b0, out_valid=0, busy=0, in_ready=1, FIFO empty, FSM=IDLE, counter=0.
- Push: in_valid && in_ready at a clock edge writes in_data at the write pointer.
- Full FIFO: in_ready=0. in_valid is ignored with no drop and no overwrite. There is no pass-through, so a pop in the same cycle does not make room that cycle.
- Pointer behaviour: pointers wrap modulo FIFO_DEPTH. Occupancy uses a count of width clog2(FIFO_DEPTH)+1.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, load out_data=1<<code, set out_valid=1 and cnt=PULSE_LEN-1, then go to PULSE. Otherwise stay, with outputs zero.
  - PULSE: hold out_data. If cnt!=0, decrement. If cnt==0, clear out_data/out_valid, load cnt=GAP_LEN-1 and go to GAP.
  - GAP: output zero. If cnt!=0, decrement. If cnt==0 and the FIFO is non-empty, pop and load the next strobe directly into PULSE (same actions as IDLE). If cnt==0 and the FIFO is empty, go to IDLE.
- out_data is always either zero or exactly one-hot. It is never multi-hot, including across state transitions.
- Codes are emitted in FIFO order. None is lost or duplicated.
- Reset asserted mid-pulse or mid-gap: outputs go to zero immediately (asynchronously), the FIFO is flushed and the FSM returns to IDLE. After release, the first edge behaves as from a fresh reset.

## Timing
- Latency: for a code pushed at edge N into an empty, idle block, out_data becomes valid after edge N+1 (one cycle from the push).
- Each strobe is held exactly PULSE_LEN cycles.
- Between back-to-back buffered codes, out_data is zero for exactly GAP_LEN cycles.
- Sustained throughput: one code per PULSE_LEN+GAP_LEN cycles. in_ready deasserts once FIFO_DEPTH codes are waiting.
- Pop timing: a pop happens on the edge that loads out_data. in_ready rises the cycle after that pop.
- busy falls on the edge that enters IDLE with the FIFO empty.

## Test plan
- Reset and single code: hold rst_n=0 for 2 cycles, then push code 3'd5 at edge N. Required: out_data=8'b00100000 after edge N+1 for 2 cycles, then 0. busy=0 after the gap.
- Every code: push 0..7 back-to-back (default parameters). Required: out_data sequence 01,02,04,...,80, each held 2 cycles with 1 zero cycle between. out_valid matches the non-zero cycles.
- Full FIFO back-pressure: push 6 codes continuously. Required: in_ready=0 after 4 codes are waiting; no code lost; the emitted order matches the push order.
- Simultaneous push and pop at full: present in_valid on the cycle the head pops. Required: the push is not accepted that cycle, and is accepted the following cycle.
- Reset mid-pulse: push 3'd2 and 3'd6, then assert rst_n=0 during the first strobe. Required: out_data=0 immediately. After release, no strobe for 3'd6 appears.
- Parameter sweep: PULSE_LEN=1, GAP_LEN=3 with codes 3'd1 then 3'd7. Required: 8'h02 for 1 cycle, zero for 3 cycles, then 8'h80 for 1 cycle.
